// File: rtl/pcie_tlp_rx_axi_wr_pkg.sv
// Shared codes for the inbound MWr-TLP to AXI-write bridge: TLP header codes,
// AXI constants, FSM states and the TLP acceptance rule.
package pcie_tlp_rx_axi_wr_pkg;

    localparam logic [2:0] FMT_MWR_3DW    = 3'b010;
    localparam logic [4:0] TYPE_MEM       = 5'b00000;
    localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;
    localparam logic [2:0] AXI_SIZE_16B   = 3'b100;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_RESP
    } state_t;

    // A TLP is replayable only if its payload fits inside the one 16-byte beat.
    function automatic logic mwr_supported(input logic [2:0] fmt,
                                           input logic [4:0] typ,
                                           input logic [8:0] length,
                                           input logic [1:0] off);
        logic [9:0] end_dw;
        end_dw = {8'b0, off} + {1'b0, length};
        return (fmt == FMT_MWR_3DW) && (typ == TYPE_MEM) &&
               (length != 9'd0) && (end_dw <= 10'd4);
    endfunction

endpackage

// File: rtl/pcie_tlp_wr_align.sv
// Places a DW-aligned payload into its byte lanes of the 16-byte AXI beat and
// builds the matching write strobe.
module pcie_tlp_wr_align #(
    parameter int DATA_W = 128
) (
    input  logic [1:0]          off,
    input  logic [2:0]          length,
    input  logic [DATA_W-1:0]   data,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb
);
    localparam int LANES = DATA_W / 32;

    logic [3:0] end_lane;

    assign wdata    = data << (32 * off);
    assign end_lane = {2'b0, off} + {1'b0, length};

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign wstrb[4*gi +: 4] = {4{(4'(gi) >= {2'b0, off}) && (4'(gi) < end_lane)}};
        end
    endgenerate

endmodule

// File: rtl/pcie_tlp_rx_axi_wr.sv
// Inbound PCIe Memory-Write TLP to single-beat AXI write bridge; one TLP in
// flight, unsupported TLPs dropped and counted.
module pcie_tlp_rx_axi_wr
    import pcie_tlp_rx_axi_wr_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4,
    parameter int ERR_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tlp_valid_i,
    output logic                tlp_ready_o,
    input  logic [2:0]          tlp_fmt_i,
    input  logic [4:0]          tlp_type_i,
    input  logic [2:0]          tlp_tc_i,
    input  logic [8:0]          tlp_length_i,
    input  logic [15:0]         tlp_reqid_i,
    input  logic [ADDR_W-1:0]   tlp_addr_i,
    input  logic [DATA_W-1:0]   tlp_data_i,
    output logic [ID_W-1:0]     awid,
    output logic [ADDR_W-1:0]   awaddr,
    output logic [3:0]          awlen,
    output logic [2:0]          awsize,
    output logic [1:0]          awburst,
    output logic                awvalid,
    input  logic                awready,
    output logic [ID_W-1:0]     wid,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wlast,
    output logic                wvalid,
    input  logic                wready,
    input  logic [ID_W-1:0]     bid,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready,
    output logic                wr_done_o,
    output logic                wr_err_o,
    output logic [ERR_W-1:0]    drop_cnt_o
);
    state_t              state_reg;
    logic                ready_reg;
    logic                awvalid_reg;
    logic                wvalid_reg;
    logic                bready_reg;
    logic                done_reg;
    logic                err_reg;
    logic [ID_W-1:0]     tag_reg;
    logic [ERR_W-1:0]    drop_cnt_reg;
    logic [2:0]          fmt_reg;
    logic [4:0]          type_reg;
    logic [8:0]          length_reg;
    logic [ADDR_W-1:2]   addr_reg;
    logic [DATA_W-1:0]   data_reg;
    logic [ADDR_W-1:0]   awaddr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [DATA_W/8-1:0] wstrb_reg;
    logic [DATA_W-1:0]   align_wdata;
    logic [DATA_W/8-1:0] align_wstrb;

    // Traffic class, requester ID and the sub-DW address bits play no part in the write.
    logic unused_inputs;
    assign unused_inputs = ^{tlp_tc_i, tlp_reqid_i, tlp_addr_i[1:0]};

    pcie_tlp_wr_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .off    (addr_reg[3:2]),
        .length (length_reg[2:0]),
        .data   (data_reg),
        .wdata  (align_wdata),
        .wstrb  (align_wstrb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ready_reg    <= 1'b0;
            awvalid_reg  <= 1'b0;
            wvalid_reg   <= 1'b0;
            bready_reg   <= 1'b0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
            tag_reg      <= '0;
            drop_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ready_reg && tlp_valid_i) begin
                        fmt_reg    <= tlp_fmt_i;
                        type_reg   <= tlp_type_i;
                        length_reg <= tlp_length_i;
                        addr_reg   <= tlp_addr_i[ADDR_W-1:2];
                        data_reg   <= tlp_data_i;
                        ready_reg  <= 1'b0;
                        state_reg  <= ST_CHECK;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mwr_supported(fmt_reg, type_reg, length_reg, addr_reg[3:2])) begin
                        awaddr_reg  <= {addr_reg[ADDR_W-1:4], 4'b0};
                        wdata_reg   <= align_wdata;
                        wstrb_reg   <= align_wstrb;
                        awvalid_reg <= 1'b1;
                        wvalid_reg  <= 1'b1;
                        state_reg   <= ST_ISSUE;
                    end else begin
                        if (drop_cnt_reg != {ERR_W{1'b1}}) begin
                            drop_cnt_reg <= drop_cnt_reg + 1'b1;
                        end
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (awready) awvalid_reg <= 1'b0;
                    if (wready) wvalid_reg <= 1'b0;
                    // Each channel is finished once its valid is gone or is being taken now.
                    if ((!awvalid_reg || awready) && (!wvalid_reg || wready)) begin
                        bready_reg <= 1'b1;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bvalid) begin
                        bready_reg <= 1'b0;
                        if ((bid == tag_reg) && (bresp == AXI_RESP_OKAY)) begin
                            done_reg <= 1'b1;
                        end else begin
                            err_reg <= 1'b1;
                        end
                        tag_reg   <= tag_reg + 1'b1;
                        ready_reg <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tlp_ready_o = ready_reg;
    assign awid        = tag_reg;
    assign awaddr      = awaddr_reg;
    assign awlen       = AXI_LEN_SINGLE;
    assign awsize      = AXI_SIZE_16B;
    assign awburst     = AXI_BURST_INCR;
    assign awvalid     = awvalid_reg;
    assign wid         = tag_reg;
    assign wdata       = wdata_reg;
    assign wstrb       = wstrb_reg;
    assign wlast       = 1'b1;
    assign wvalid      = wvalid_reg;
    assign bready      = bready_reg;
    assign wr_done_o   = done_reg;
    assign wr_err_o    = err_reg;
    assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_pcie_tlp_rx_axi_wr.sv
// Bench for pcie_tlp_rx_axi_wr: drives TLPs, acts as the AXI slave and checks
// each replayed write against a scoreboard of expected beats.
module tb_pcie_tlp_rx_axi_wr;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int ID_W   = 4;
    localparam int ERR_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                tlp_valid;
    logic                tlp_ready;
    logic [2:0]          tlp_fmt;
    logic [4:0]          tlp_type;
    logic [2:0]          tlp_tc;
    logic [8:0]          tlp_length;
    logic [15:0]         tlp_reqid;
    logic [ADDR_W-1:0]   tlp_addr;
    logic [DATA_W-1:0]   tlp_data;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     wid;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic                wr_done;
    logic                wr_err;
    logic [ERR_W-1:0]    drop_cnt;

    typedef struct {
        logic [31:0]  awaddr;
        logic [127:0] wdata;
        logic [15:0]  wstrb;
        logic [3:0]   id;
    } exp_t;

    exp_t       exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    logic [3:0] model_tag = 4'd0;

    always #5 clk = ~clk;

    pcie_tlp_rx_axi_wr #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .ERR_W(ERR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .tlp_valid_i(tlp_valid), .tlp_ready_o(tlp_ready),
        .tlp_fmt_i(tlp_fmt), .tlp_type_i(tlp_type), .tlp_tc_i(tlp_tc),
        .tlp_length_i(tlp_length), .tlp_reqid_i(tlp_reqid),
        .tlp_addr_i(tlp_addr), .tlp_data_i(tlp_data),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .wr_done_o(wr_done), .wr_err_o(wr_err), .drop_cnt_o(drop_cnt)
    );

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests_run++;
        if (got !== want) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_mwr(input logic [31:0] addr, input int len, input logic [127:0] data);
        exp_t        e;
        int          off;
        logic [31:0] mask;
        off      = int'(addr[3:2]);
        mask     = ((32'h1 << (4 * len)) - 32'h1) << (4 * off);
        e.awaddr = addr & ~32'hF;
        e.wdata  = data << (32 * off);
        e.wstrb  = mask[15:0];
        e.id     = model_tag;
        exp_q.push_back(e);
    endtask

    task automatic send_tlp(input logic [2:0] fmt, input logic [4:0] typ, input logic [8:0] len,
                            input logic [31:0] addr, input logic [127:0] data);
        int n;
        n = 0;
        while (!tlp_ready && n < 20) begin
            tick();
            n++;
        end
        chk("tlp_ready", tlp_ready, 1'b1);
        tlp_valid  = 1'b1;
        tlp_fmt    = fmt;
        tlp_type   = typ;
        tlp_length = len;
        tlp_addr   = addr;
        tlp_data   = data;
        tlp_tc     = 3'($urandom_range(7));
        tlp_reqid  = 16'($urandom);
        tick();
        tlp_valid = 1'b0;
    endtask

    task automatic pop_and_check_aw(output exp_t e);
        if (exp_q.size() == 0) begin
            chk("scoreboard_nonempty", 0, 1);
            e = '{default: '0};
        end else begin
            e = exp_q.pop_front();
            chk("awaddr", awaddr, e.awaddr);
            chk("awid", awid, e.id);
            chk("wid", wid, e.id);
            chk("wdata", wdata, e.wdata);
            chk("wstrb", wstrb, e.wstrb);
            chk("aw_w_consts", {awlen, awsize, awburst, wlast}, {4'd0, 3'b100, 2'b01, 1'b1});
        end
    endtask

    // Starts right after the TLP accept edge; plays the AXI slave to completion.
    task automatic axi_write(input int aw_stall, input logic [1:0] resp, input bit bad_id);
        exp_t e;
        int   n;
        int   cyc;
        bit   aw_hs;
        bit   w_hs;
        bit   aw_fire;
        bit   w_fire;
        bit   ok;
        n = 0;
        while (!awvalid && n < 10) begin
            tick();
            n++;
        end
        chk("aw_latency", n, 1);
        chk("wvalid_with_aw", wvalid, 1'b1);
        pop_and_check_aw(e);
        aw_hs = 0;
        w_hs  = 0;
        cyc   = 0;
        while (!(aw_hs && w_hs) && cyc < 40) begin
            awready = (cyc >= aw_stall);
            wready  = 1'b1;
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            if (!aw_hs) chk("awaddr_stable", awaddr, e.awaddr);
            chk("bready_before_hs", bready, 1'b0);
            tick();
            if (aw_fire) aw_hs = 1;
            if (w_fire) w_hs = 1;
            if (w_hs) chk("wvalid_dropped", wvalid, 1'b0);
            if (aw_hs) chk("awvalid_dropped", awvalid, 1'b0);
            cyc++;
        end
        awready = 1'b0;
        wready  = 1'b0;
        chk("handshakes", {aw_hs, w_hs}, 2'b11);
        chk("bready_up", bready, 1'b1);
        bvalid = 1'b1;
        bid    = bad_id ? (model_tag ^ 4'd1) : model_tag;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        ok = !bad_id && (resp == 2'b00);
        chk("wr_done", wr_done, ok);
        chk("wr_err", wr_err, !ok);
        model_tag = model_tag + 4'd1;
        tick();
        chk("pulse_single", {wr_done, wr_err}, 2'b00);
        chk("bready_down", bready, 1'b0);
        $display("[TB] write addr=%08h id=%0d stall=%0d resp=%0d bad_id=%0d", e.awaddr, e.id, aw_stall, resp, bad_id);
    endtask

    task automatic do_mwr(input logic [31:0] addr, input int len, input logic [127:0] data,
                          input int aw_stall, input logic [1:0] resp, input bit bad_id);
        expect_mwr(addr, len, data);
        send_tlp(3'b010, 5'b00000, 9'(len), addr, data);
        axi_write(aw_stall, resp, bad_id);
    endtask

    task automatic do_drop(input logic [2:0] fmt, input logic [8:0] len, input logic [31:0] addr);
        bit seen;
        send_tlp(fmt, 5'b00000, len, addr, {4{32'hA5A5A5A5}});
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (awvalid || wvalid) seen = 1;
            tick();
        end
        chk("drop_no_axi", seen, 1'b0);
        $display("[TB] drop fmt=%0d len=%0d addr=%08h cnt=%0d", fmt, len, addr, drop_cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        tlp_valid = 0; tlp_fmt = 0; tlp_type = 0; tlp_tc = 0; tlp_length = 0;
        tlp_reqid = 0; tlp_addr = 0; tlp_data = 0;
        awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
        repeat (3) tick();
        chk("rst_tlp_ready", tlp_ready, 1'b0);
        chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("rst_pulses", {wr_done, wr_err}, 2'b00);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        tick();
        tick();
        chk("idle_ready", tlp_ready, 1'b1);

        do_mwr(32'h0, 4, {4{32'h01234567}}, 0, 2'b00, 0);
        do_mwr(32'h24, 1, {96'h0, 32'hDEADBEEF}, 0, 2'b00, 0);
        do_mwr(32'h1008, 2, {64'h0, 64'h11112222_33334444}, 5, 2'b00, 0);
        do_mwr(32'h4, 3, {32'h0, 96'hAAAA_BBBB_CCCC}, 0, 2'b10, 0);
        do_mwr(32'h3C, 1, {96'h0, 32'h55667788}, 2, 2'b00, 1);

        do_drop(3'b000, 9'd1, 32'h0);
        do_drop(3'b010, 9'd0, 32'h0);
        do_drop(3'b010, 9'd5, 32'h0);
        do_drop(3'b010, 9'd3, 32'h8);
        chk("drop_cnt", drop_cnt, 4);

        for (int i = 0; i < 17; i++) begin
            do_mwr(32'h100 + 32'(i * 4), 1 + (i % 4 == 3 ? 0 : 0), {4{32'(i) * 32'h01010101}}, i % 3, 2'b00, 0);
        end

        // Abandon a write while it is waiting in the issue state.
        expect_mwr(32'h2000, 4, {4{32'hCAFEF00D}});
        send_tlp(3'b010, 5'b00000, 9'd4, 32'h2000, {4{32'hCAFEF00D}});
        n = 0;
        while (!awvalid && n < 10) begin
            tick();
            n++;
        end
        chk("rst_case_aw", awvalid, 1'b1);
        pop_and_check_aw(e);
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_valids", {awvalid, wvalid, bready}, 3'b000);
        chk("midrst_tlp_ready", tlp_ready, 1'b0);
        chk("midrst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        model_tag = 4'd0;
        $display("[TB] reset during issue");
        do_mwr(32'h3000, 2, {64'h0, 64'h0BAD_F00D_1234_5678}, 0, 2'b00, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
